// File: rtl/demux_collect.sv
// demux_collect: reassembles a LANES-bit word from lane-tagged serial bits.
// Each valid bit is written into its lane; the word is emitted with a
// one-cycle out_valid pulse once every lane has been seen. A repeated lane
// restarts the word from the offending bit (dup_err). A partial word left
// idle for TIMEOUT cycles is dropped (timeout_err).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no partial word held; mask is zero
// COLLECT | at least one lane captured, waiting for the rest
module demux_collect #(
    parameter int LANES   = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic [SEL_W-1:0] select,
    output logic [LANES-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             dup_err,
    output logic             timeout_err
);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t           state, state_n;
    logic [LANES-1:0] word, word_n;
    logic [LANES-1:0] mask, mask_n;
    logic [7:0]       idle_cnt, idle_n;
    logic [LANES-1:0] out_n;
    logic             out_valid_n, dup_n, timeout_n;
    logic [LANES-1:0] sel_oh, cap_word, cap_mask;

    // Next-state, assembly and output decode for one cycle.
    always_comb begin
        state_n     = state;
        word_n      = word;
        mask_n      = mask;
        idle_n      = idle_cnt;
        out_n       = out;
        out_valid_n = 1'b0;
        dup_n       = 1'b0;
        timeout_n   = 1'b0;

        sel_oh           = {{(LANES-1){1'b0}}, 1'b1} << select;
        cap_word         = word;
        cap_word[select] = in;
        cap_mask         = mask | sel_oh;

        if (in_valid) begin
            idle_n = 8'd0;
            if ((state == COLLECT) && mask[select]) begin
                // The repeated bit is kept as the first bit of a fresh word.
                dup_n          = 1'b1;
                word_n         = '0;
                word_n[select] = in;
                mask_n         = sel_oh;
                state_n        = COLLECT;
            end else if (&cap_mask) begin
                out_n       = cap_word;
                out_valid_n = 1'b1;
                word_n      = '0;
                mask_n      = '0;
                state_n     = IDLE;
            end else begin
                word_n  = cap_word;
                mask_n  = cap_mask;
                state_n = COLLECT;
            end
        end else if (state == COLLECT) begin
            if (idle_cnt == 8'(TIMEOUT - 1)) begin
                timeout_n = 1'b1;
                word_n    = '0;
                mask_n    = '0;
                idle_n    = 8'd0;
                state_n   = IDLE;
            end else begin
                idle_n = idle_cnt + 8'd1;
            end
        end
    end

    // State, assembly registers and registered outputs; reset discards silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            mask        <= '0;
            idle_cnt    <= 8'd0;
            out         <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            dup_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            word        <= word_n;
            mask        <= mask_n;
            idle_cnt    <= idle_n;
            out         <= out_n;
            out_valid   <= out_valid_n;
            busy        <= (state_n == COLLECT);
            dup_err     <= dup_n;
            timeout_err <= timeout_n;
        end
    end

endmodule

// File: doc/demux_collect.md
Name: demux_collect

Overview:
- Receive-side counterpart of the team's 4:1 selector (4-bit `in`, 2-bit `select`, 1-bit `out`).
- Accepts one serial bit per valid cycle, tagged with the `select` lane it came from.
- Scatters each bit into its lane and reassembles the full LANES-bit word.
- Emits the word with a one-cycle valid pulse. Flags duplicate-lane and idle-timeout errors so the upstream serializer can be resynchronised.

Parameters:
- LANES, 4: number of lanes and output word width; must be a power of 2, at least 2.
- SEL_W, 2: select width; must equal log2(LANES).
- TIMEOUT, 15: idle cycles allowed mid-word before the partial word is discarded; range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  `in` and `select` are meaningful this cycle
- in  input  1  serial data bit
- select  input  SEL_W  lane index for `in`
- out  output  LANES  last completed word, held until the next completion
- out_valid  output  1  one-cycle pulse; `out` is updated in the same cycle
- busy  output  1  high while a partial word is held (state COLLECT)
- dup_err  output  1  one-cycle pulse on a duplicate lane
- timeout_err  output  1  one-cycle pulse on an idle timeout

Behaviour:
- Internal state:
  - word[LANES-1:0]: assembly register.
  - mask[LANES-1:0]: lanes captured so far.
  - idle_cnt: 8 bits.
  - FSM with states IDLE and COLLECT.
- Reset (rst=1 at a clk edge):
  - out=0, out_valid=0, busy=0, dup_err=0, timeout_err=0.
  - word=0, mask=0, idle_cnt=0, state=IDLE.
  - Reset overrides all other events; a partial word is discarded silently with no error pulse.
- All outputs are registered. out_valid, dup_err and timeout_err default to 0 every cycle unless set by the rules below.
- Capture (in_valid=1, no duplicate):
  - word[select] <= in; mask[select] <= 1; idle_cnt <= 0.
- Duplicate (state COLLECT, in_valid=1, mask[select] already 1):
  - dup_err <= 1.
  - mask <= one-hot(select); word <= 0 with word[select] <= in.
  - idle_cnt <= 0; state stays COLLECT, so the offending bit starts the new word.
- Completion: when a capture makes mask all-ones (counting the bit captured this cycle):
  - out <= completed word; out_valid <= 1.
  - mask <= 0, word <= 0, state <= IDLE.
  - Latency: out_valid is high in the cycle after the edge that sampled the last lane's bit.
  - Lanes may arrive in any order.
  - LANES=1 is not supported.
- FSM transitions:
  - IDLE -> COLLECT: first capture that does not complete the word.
  - COLLECT -> IDLE: on completion, or on timeout.
  - COLLECT -> COLLECT: on a duplicate.
- Timeout (state COLLECT, in_valid=0):
  - idle_cnt increments each such cycle.
  - On the edge where idle_cnt would reach TIMEOUT: timeout_err <= 1, mask <= 0, word <= 0, idle_cnt <= 0, state <= IDLE.
  - `out` is unchanged.
- IDLE with in_valid=0: nothing changes; idle_cnt stays 0.
- Simultaneous events:
  - in_valid=1 on the cycle the count would expire: the capture wins, no timeout.
  - in_valid=1 during an out_valid cycle: accepted as the first bit of the next word, with no bubble.
  - Back-to-back words therefore sustain 1 word per LANES cycles.
- `select` is ignored when in_valid=0.
- busy = (state==COLLECT), registered alongside state.

Test Plan:
1. Reset, then in_valid=1 for 4 cycles with select=0,1,2,3 and in=1,0,1,1 → one cycle later out=4'b1101, out_valid=1 for exactly 1 cycle, busy=0.
2. Out-of-order lanes: select=3,1,0,2 with in=1,1,0,0 → out=4'b1010, out_valid pulse 1 cycle after the 4th bit. Immediately feed the next word (select 0..3, in=1,1,1,1) with no gap → out=4'b1111 exactly 4 cycles after the first pulse.
3. Duplicate: select=0 (in=1), select=1 (in=1), select=1 (in=0) → dup_err pulses on the 3rd bit, busy stays 1. Then select=0,2,3 with in=1,1,0 → out=4'b0101.
4. Timeout (TIMEOUT=15): capture select=2, then in_valid=0 for 15 cycles → timeout_err pulses once, busy=0, out unchanged. Variant: in_valid=1 on the 15th idle cycle → no timeout_err, capture accepted.
5. Reset mid-word: capture lanes 0 and 1, assert rst for 1 cycle → all outputs 0, no error pulses. Then a full word 0,1,2,3 with in=0,1,1,0 → out=4'b0110.
6. Gaps below timeout: bits separated by 14 idle cycles each (select 0..3, in=1,0,0,1) → out=4'b1001, no timeout_err.
